// File: rtl/traffic_pkg.sv
// Shared encodings for the crossing controller: FSM states and light codes.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package traffic_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ALL_RED,
        ST_A_GRN,
        ST_A_YEL1,
        ST_A_LEFT,
        ST_A_YEL2,
        ST_B_GRN,
        ST_B_YEL1,
        ST_B_LEFT,
        ST_B_YEL2,
        ST_FLASH
    } state_t;

    localparam logic [3:0] CAR_RED    = 4'b1000;
    localparam logic [3:0] CAR_YELLOW = 4'b0100;
    localparam logic [3:0] CAR_LEFT   = 4'b0010;
    localparam logic [3:0] CAR_GREEN  = 4'b0001;
    localparam logic [3:0] CAR_NONE   = 4'b0000;

    localparam logic [1:0] WALK_RED   = 2'b10;
    localparam logic [1:0] WALK_GREEN = 2'b01;
    localparam logic [1:0] WALK_NONE  = 2'b00;

    // Walker light while the opposite approach is served. 'elapsed' counts
    // cycles since that approach's green began: steady green, then blink
    // starting on green, then red. A walker with no pending request stays red.
    function automatic logic [1:0] walk_light(input logic        serve,
                                              input logic [31:0] elapsed,
                                              input int          t_walk,
                                              input int          t_blink);
        if (!serve) begin
            return WALK_RED;
        end
        if (elapsed < 32'(t_walk)) begin
            return WALK_GREEN;
        end
        if (elapsed < 32'(t_walk + t_blink)) begin
            if (((elapsed - 32'(t_walk)) & 32'd1) != 32'd0) begin
                return WALK_NONE;
            end
            return WALK_GREEN;
        end
        return WALK_RED;
    endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Phase down-counter: load a value, count down to zero while enabled, then hold.
// Latency: load and decrement take effect on the next clock edge; zero flag is combinational.
// Backpressure: i_en low freezes the count (run-enable stall).
module traffic_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_value,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority; otherwise count down when enabled, saturating at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_value = r_cnt;
    assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/traffic_xing_ctrl.sv
// Two-approach crossing controller with left-turn phases, walker lights and flashing mode.
// Latency: lights are a combinational decode of registered state/timer/pending bits; state moves on clk.
// Backpressure: i_start low freezes state and timer and blanks all lights; ped requests still latch.
module traffic_xing_ctrl
    import traffic_pkg::*;
#(
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 2,
    parameter int T_LEFT   = 10,
    parameter int T_ALLRED = 2,
    parameter int T_WALK   = 14,
    parameter int T_BLINK  = 6,
    parameter int CNT_W    = 8,
    parameter int FIRST_B  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_flash,
    input  logic       i_ped_req_a,
    input  logic       i_ped_req_b,
    output logic [3:0] o_car_a,
    output logic [3:0] o_car_b,
    output logic [1:0] o_walk_a,
    output logic [1:0] o_walk_b,
    output logic [1:0] o_ped_pend
);

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_cnt;
    logic             w_zero;
    logic             w_enter_a_grn;
    logic             w_enter_b_grn;
    logic [31:0]      w_elapsed;
    logic             r_pend_a;
    logic             r_pend_b;
    logic             r_serve_a;
    logic             r_serve_b;
    logic             r_flash_ph;

    traffic_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_value (w_load_val),
        .i_en    (i_start),
        .o_value (w_cnt),
        .o_zero  (w_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: flash overrides everything; timed phases advance on zero count.
    always_comb begin
        w_next = r_state;
        if (i_start) begin
            if (i_flash) begin
                w_next = ST_FLASH;
            end else begin
                case (r_state)
                    ST_IDLE:    w_next = ST_ALL_RED;
                    ST_FLASH:   w_next = ST_ALL_RED;
                    ST_ALL_RED: if (w_zero) w_next = (FIRST_B != 0) ? ST_B_GRN : ST_A_GRN;
                    ST_A_GRN:   if (w_zero) w_next = ST_A_YEL1;
                    ST_A_YEL1:  if (w_zero) w_next = ST_A_LEFT;
                    ST_A_LEFT:  if (w_zero) w_next = ST_A_YEL2;
                    ST_A_YEL2:  if (w_zero) w_next = ST_B_GRN;
                    ST_B_GRN:   if (w_zero) w_next = ST_B_YEL1;
                    ST_B_YEL1:  if (w_zero) w_next = ST_B_LEFT;
                    ST_B_LEFT:  if (w_zero) w_next = ST_B_YEL2;
                    ST_B_YEL2:  if (w_zero) w_next = ST_A_GRN;
                    default:    w_next = ST_IDLE;
                endcase
            end
        end
    end

    // Timer reload on every state change, with the entered phase's duration minus one.
    always_comb begin
        w_load     = (w_next != r_state);
        w_load_val = '0;
        case (w_next)
            ST_ALL_RED:                                    w_load_val = CNT_W'(T_ALLRED - 1);
            ST_A_GRN, ST_B_GRN:                            w_load_val = CNT_W'(T_GREEN - 1);
            ST_A_YEL1, ST_A_YEL2, ST_B_YEL1, ST_B_YEL2:   w_load_val = CNT_W'(T_YELLOW - 1);
            ST_A_LEFT, ST_B_LEFT:                          w_load_val = CNT_W'(T_LEFT - 1);
            default:                                       w_load_val = '0;
        endcase
    end

    assign w_enter_a_grn = (w_next == ST_A_GRN) && (r_state != ST_A_GRN);
    assign w_enter_b_grn = (w_next == ST_B_GRN) && (r_state != ST_B_GRN);

    // Pending requests latch at all times; entering the opposite green turns the
    // pending bit (or a request arriving on that same edge) into a serve flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_a  <= 1'b0;
            r_pend_b  <= 1'b0;
            r_serve_a <= 1'b0;
            r_serve_b <= 1'b0;
        end else begin
            if (w_enter_b_grn) begin
                r_serve_a <= r_pend_a | i_ped_req_a;
                r_pend_a  <= 1'b0;
            end else if (i_ped_req_a) begin
                r_pend_a  <= 1'b1;
            end
            if (w_enter_a_grn) begin
                r_serve_b <= r_pend_b | i_ped_req_b;
                r_pend_b  <= 1'b0;
            end else if (i_ped_req_b) begin
                r_pend_b  <= 1'b1;
            end
        end
    end

    // Flash phase: zero on entry so yellow shows first, toggles per running cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flash_ph <= 1'b0;
        end else if (r_state != ST_FLASH) begin
            r_flash_ph <= 1'b0;
        end else if (i_start) begin
            r_flash_ph <= ~r_flash_ph;
        end
    end

    // Cycles elapsed since the serving approach's green began, rebuilt from the
    // down-count so no separate walker counter is needed.
    always_comb begin
        w_elapsed = '0;
        case (r_state)
            ST_A_GRN, ST_B_GRN:
                w_elapsed = 32'(T_GREEN) - 32'(w_cnt) - 32'd1;
            ST_A_YEL1, ST_B_YEL1:
                w_elapsed = 32'(T_GREEN + T_YELLOW) - 32'(w_cnt) - 32'd1;
            ST_A_LEFT, ST_B_LEFT:
                w_elapsed = 32'(T_GREEN + T_YELLOW + T_LEFT) - 32'(w_cnt) - 32'd1;
            ST_A_YEL2, ST_B_YEL2:
                w_elapsed = 32'(T_GREEN + 2 * T_YELLOW + T_LEFT) - 32'(w_cnt) - 32'd1;
            default:
                w_elapsed = '0;
        endcase
    end

    // Light decode; everything dark while stopped or idle.
    always_comb begin
        o_car_a  = CAR_NONE;
        o_car_b  = CAR_NONE;
        o_walk_a = WALK_NONE;
        o_walk_b = WALK_NONE;
        if (i_start) begin
            case (r_state)
                ST_ALL_RED: begin
                    o_car_a  = CAR_RED;
                    o_car_b  = CAR_RED;
                    o_walk_a = WALK_RED;
                    o_walk_b = WALK_RED;
                end
                ST_A_GRN, ST_A_YEL1, ST_A_LEFT, ST_A_YEL2: begin
                    o_car_a  = (r_state == ST_A_GRN)  ? CAR_GREEN :
                               (r_state == ST_A_LEFT) ? CAR_LEFT  : CAR_YELLOW;
                    o_car_b  = CAR_RED;
                    o_walk_a = WALK_RED;
                    o_walk_b = walk_light(r_serve_b, w_elapsed, T_WALK, T_BLINK);
                end
                ST_B_GRN, ST_B_YEL1, ST_B_LEFT, ST_B_YEL2: begin
                    o_car_a  = CAR_RED;
                    o_car_b  = (r_state == ST_B_GRN)  ? CAR_GREEN :
                               (r_state == ST_B_LEFT) ? CAR_LEFT  : CAR_YELLOW;
                    o_walk_a = walk_light(r_serve_a, w_elapsed, T_WALK, T_BLINK);
                    o_walk_b = WALK_RED;
                end
                ST_FLASH: begin
                    o_car_a = r_flash_ph ? CAR_NONE : CAR_YELLOW;
                    o_car_b = r_flash_ph ? CAR_NONE : CAR_YELLOW;
                end
                default: begin
                    o_car_a = CAR_NONE;
                end
            endcase
        end
    end

    assign o_ped_pend = {r_pend_b, r_pend_a};

endmodule

// File: tb/tb_traffic_xing_ctrl.sv
// Bench for traffic_xing_ctrl: directed vector table, hand sequences, random run vs. reference model.
// Latency: checks sampled 1 time unit after the rising edge.
// Backpressure: i_start toggled to exercise stall/blanking.
module tb_traffic_xing_ctrl;

    localparam int LT_GREEN  = 20;
    localparam int LT_YELLOW = 2;
    localparam int LT_LEFT   = 10;
    localparam int LT_ALLRED = 2;
    localparam int LT_WALK   = 14;
    localparam int LT_BLINK  = 6;

    localparam logic [3:0] R = 4'b1000, Y = 4'b0100, L = 4'b0010, G = 4'b0001, N = 4'b0000;
    localparam logic [1:0] WR = 2'b10, WG = 2'b01, WN = 2'b00;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_start = 1'b0, i_flash = 1'b0, i_ped_req_a = 1'b0, i_ped_req_b = 1'b0;
    logic [3:0] o_car_a, o_car_b;
    logic [1:0] o_walk_a, o_walk_b, o_ped_pend;

    int n_cmp = 0;
    int n_err = 0;

    traffic_xing_ctrl #(
        .T_GREEN (LT_GREEN), .T_YELLOW (LT_YELLOW), .T_LEFT (LT_LEFT),
        .T_ALLRED(LT_ALLRED), .T_WALK (LT_WALK), .T_BLINK (LT_BLINK),
        .CNT_W   (8), .FIRST_B (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_flash    (i_flash),
        .i_ped_req_a(i_ped_req_a),
        .i_ped_req_b(i_ped_req_b),
        .o_car_a    (o_car_a),
        .o_car_b    (o_car_b),
        .o_walk_a   (o_walk_a),
        .o_walk_b   (o_walk_b),
        .o_ped_pend (o_ped_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [3:0] ca, input logic [3:0] cb,
                         input logic [1:0] wa, input logic [1:0] wb, input logic [1:0] pd);
        n_cmp++;
        if ({o_car_a, o_car_b, o_walk_a, o_walk_b, o_ped_pend} !== {ca, cb, wa, wb, pd}) begin
            n_err++;
            $display("FAIL %s: got car_a=%b car_b=%b walk_a=%b walk_b=%b pend=%b, want car_a=%b car_b=%b walk_a=%b walk_b=%b pend=%b",
                     nm, o_car_a, o_car_b, o_walk_a, o_walk_b, o_ped_pend, ca, cb, wa, wb, pd);
        end
    endtask

    // Drive inputs, then advance n edges (n=0: just let combinational outputs settle).
    task automatic apply(input logic st, input logic fl, input logic ra, input logic rb, input int n);
        i_start = st; i_flash = fl; i_ped_req_a = ra; i_ped_req_b = rb;
        if (n == 0) begin
            #1;
        end else begin
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    typedef struct {
        logic st, fl, ra, rb;
        int   n;
        logic [3:0] ca, cb;
        logic [1:0] wa, wb, pd;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    // ---------------- reference model: phase index + up-counting time ----------------
    // mode 0 idle, 1 running, 2 flashing; ph 0 = all-red, 1..4 A phases, 5..8 B phases.
    int m_mode, m_ph, m_el, m_win, m_fcnt;
    bit m_pend_a, m_pend_b, m_srv_a, m_srv_b;

    function automatic int dur(input int ph);
        if (ph == 0) return LT_ALLRED;
        case ((ph - 1) % 4)
            0:       return LT_GREEN;
            2:       return LT_LEFT;
            default: return LT_YELLOW;
        endcase
    endfunction

    function automatic logic [1:0] m_walker(input bit srv, input int e);
        if (!srv) return WR;
        if (e < LT_WALK) return WG;
        if (e < LT_WALK + LT_BLINK) return ((e - LT_WALK) % 2 == 1) ? WN : WG;
        return WR;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ph = 0; m_el = 0; m_win = 0; m_fcnt = 0;
        m_pend_a = 0; m_pend_b = 0; m_srv_a = 0; m_srv_b = 0;
    endtask

    task automatic model_step(input logic st, input logic fl, input logic ra, input logic rb);
        bit ent_a = 0;
        bit ent_b = 0;
        if (st) begin
            if (fl) begin
                if (m_mode == 2) m_fcnt++;
                else begin m_mode = 2; m_fcnt = 0; end
            end else if (m_mode != 1) begin
                m_mode = 1; m_ph = 0; m_el = 0;
            end else begin
                m_el++;
                m_win++;
                if (m_el == dur(m_ph)) begin
                    m_el = 0;
                    m_ph = (m_ph == 0 || m_ph == 8) ? 1 : m_ph + 1;
                    ent_a = (m_ph == 1);
                    ent_b = (m_ph == 5);
                    if (ent_a || ent_b) m_win = 0;
                end
            end
        end
        if (ent_a) begin m_srv_b = m_pend_b | rb; m_pend_b = 0; end
        else if (rb) m_pend_b = 1;
        if (ent_b) begin m_srv_a = m_pend_a | ra; m_pend_a = 0; end
        else if (ra) m_pend_a = 1;
    endtask

    task automatic model_check(input int cyc);
        logic [3:0] ca = N, cb = N, lt;
        logic [1:0] wa = WN, wb = WN;
        if (i_start) begin
            if (m_mode == 2) begin
                ca = (m_fcnt % 2 == 0) ? Y : N;
                cb = ca;
            end else if (m_mode == 1) begin
                if (m_ph == 0) begin
                    ca = R; cb = R; wa = WR; wb = WR;
                end else begin
                    case ((m_ph - 1) % 4)
                        0:       lt = G;
                        2:       lt = L;
                        default: lt = Y;
                    endcase
                    if (m_ph <= 4) begin
                        ca = lt; cb = R; wa = WR; wb = m_walker(m_srv_b, m_win);
                    end else begin
                        ca = R; cb = lt; wb = WR; wa = m_walker(m_srv_a, m_win);
                    end
                end
            end
        end
        check($sformatf("rand_cyc%0d", cyc), ca, cb, wa, wb, {m_pend_b, m_pend_a});
    endtask

    initial begin
        logic st_r, fl_r, ra_r, rb_r;

        //            st fl ra rb  n   car_a car_b walk_a walk_b pend
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, R, R, WR, WR, 2'b00}; // ALL_RED
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, R, R, WR, WR, 2'b00}; // ALL_RED 2nd
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, G, R, WR, WR, 2'b00}; // A_GRN
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0,  1, G, R, WR, WR, 2'b01}; // req A latched
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 18, G, R, WR, WR, 2'b01}; // last A_GRN
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, Y, R, WR, WR, 2'b01}; // A_YEL1
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0,  2, L, R, WR, WR, 2'b01}; // A_LEFT
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, Y, R, WR, WR, 2'b01}; // A_YEL2
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, Y, R, WR, WR, 2'b01}; // A_YEL2 2nd
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, R, G, WG, WR, 2'b00}; // B_GRN, walker A served
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 13, R, G, WG, WR, 2'b00}; // walk steady end
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, R, G, WG, WR, 2'b00}; // blink 0
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, R, G, WN, WR, 2'b00}; // blink 1
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, R, G, WG, WR, 2'b00}; // blink 2
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0,  3, R, G, WN, WR, 2'b00}; // blink 5, last B_GRN
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, R, Y, WR, WR, 2'b00}; // B_YEL1, walker red
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0,  2, R, L, WR, WR, 2'b00}; // B_LEFT
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0,  0, N, N, WN, WN, 2'b00}; // stopped: blank
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0,  1, N, N, WN, WN, 2'b01}; // req latches while stopped
        tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0,  0, R, L, WR, WR, 2'b01}; // resume B_LEFT
        tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0,  9, R, L, WR, WR, 2'b01}; // last B_LEFT
        tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, R, Y, WR, WR, 2'b01}; // B_YEL2
        tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, R, Y, WR, WR, 2'b01}; // B_YEL2 2nd
        tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b1,  1, G, R, WR, WG, 2'b01}; // req B on entry edge served

        // Reset and reset-state check (start high, still IDLE until the first edge).
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        apply(1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("reset_idle", N, N, WN, WN, 2'b00);

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i].st, tbl[i].fl, tbl[i].ra, tbl[i].rb, tbl[i].n);
            check($sformatf("vec%0d", i), tbl[i].ca, tbl[i].cb, tbl[i].wa, tbl[i].wb, tbl[i].pd);
        end

        // Flash mode entry, toggling, stall hold, exit through all-red.
        apply(1, 1, 0, 0, 1); check("flash_y0",   Y, Y, WN, WN, 2'b01);
        apply(1, 1, 0, 0, 1); check("flash_n1",   N, N, WN, WN, 2'b01);
        apply(1, 1, 0, 0, 1); check("flash_y2",   Y, Y, WN, WN, 2'b01);
        apply(0, 1, 0, 0, 1); check("flash_stop", N, N, WN, WN, 2'b01);
        apply(1, 1, 0, 0, 0); check("flash_hold", Y, Y, WN, WN, 2'b01);
        apply(1, 1, 0, 0, 1); check("flash_n3",   N, N, WN, WN, 2'b01);
        apply(1, 0, 0, 0, 1); check("unflash_ar0", R, R, WR, WR, 2'b01);
        apply(1, 0, 0, 0, 1); check("unflash_ar1", R, R, WR, WR, 2'b01);
        apply(1, 0, 0, 0, 1); check("unflash_agrn", G, R, WR, WR, 2'b01);

        // Stall at A_LEFT count 4, then the remaining five cycles.
        apply(1, 0, 0, 0, 27); check("aleft_cnt4", L, R, WR, WR, 2'b01);
        apply(0, 0, 0, 0, 5);  check("aleft_stop", N, N, WN, WN, 2'b01);
        apply(1, 0, 0, 0, 0);  check("aleft_resume", L, R, WR, WR, 2'b01);
        apply(1, 0, 0, 0, 4);  check("aleft_last", L, R, WR, WR, 2'b01);
        apply(1, 0, 0, 0, 1);  check("ayel2_after", Y, R, WR, WR, 2'b01);
        apply(1, 0, 0, 0, 2);  check("bgrn_served", R, G, WG, WR, 2'b00);
        apply(1, 0, 1, 0, 1);  check("bgrn_req", R, G, WG, WR, 2'b01);
        apply(1, 0, 0, 0, 4);

        // Asynchronous reset between edges, mid-B_GRN.
        #2 reset = 1'b1;
        #1 check("async_reset", N, N, WN, WN, 2'b00);
        @(posedge clk);
        #2 reset = 1'b0;
        apply(1, 0, 0, 0, 1); check("rst_allred", R, R, WR, WR, 2'b00);
        apply(1, 0, 0, 0, 2); check("rst_agrn",   G, R, WR, WR, 2'b00);

        // Random run against the reference model.
        apply(0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        model_reset();
        st_r = 1'b1; fl_r = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (st_r) st_r = ($urandom_range(0, 29) != 0);
            else      st_r = ($urandom_range(0, 3) == 0);
            if (fl_r) fl_r = ($urandom_range(0, 19) != 0);
            else      fl_r = ($urandom_range(0, 199) == 0);
            ra_r = ($urandom_range(0, 24) == 0);
            rb_r = ($urandom_range(0, 24) == 0);
            i_start = st_r; i_flash = fl_r; i_ped_req_a = ra_r; i_ped_req_b = rb_r;
            @(posedge clk);
            model_step(st_r, fl_r, ra_r, rb_r);
            #1;
            model_check(c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
